candidate_bank: RTL

Parametrised, entry-addressed storage for routing candidate records (e.g. packed neighbour ID + Q-value), with per-entry valid bits, a registered read port, a live valid-entry count and an optional argmax scan engine that reports the best valid candidate. It replaces the fixed 16-bit / 16-entry candidate store in the next-hop selection path. Each entry is one full word, so the byte-pair addressing and its wrap-around hazard at the last index no longer exist.

---
 rtl/candidate_bank.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/candidate_bank.sv
// candidate_bank: entry-addressed store of routing candidates with per-entry
// valid bits, a registered read port, a live valid count and an optional
// argmax scan engine. Define CANDBANK_SCAN_EN to build the scan engine;
// without it the scan outputs are tied to 0 and scan_start is ignored.
module candidate_bank #(
  parameter int WORD_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  inv_en,
  input  logic [ADDR_WIDTH-1:0] inv_addr,
  input  logic                  clr,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_hit,
  output logic [ADDR_WIDTH:0]   count,
  input  logic                  scan_start,
  output logic                  scan_busy,
  output logic                  scan_done,
  output logic                  best_found,
  output logic [ADDR_WIDTH-1:0] best_addr,
  output logic [WORD_WIDTH-1:0] best_data
);

  logic [WORD_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_hit_q, rd_hit_d;
  logic                  inc, dec;

  // Next valid vector and count. A same-address write overrides the
  // invalidate, so that invalidate must not decrement, keeping count equal
  // to the number of set valid bits.
  always_comb begin
    valid_d = valid_q;
    count_d = count_q;
    inc     = 1'b0;
    dec     = 1'b0;
    if (clr) begin
      valid_d = '0;
      count_d = '0;
    end else begin
      inc = wr_en && !valid_q[wr_addr];
      dec = inv_en && valid_q[inv_addr] && !(wr_en && (wr_addr == inv_addr));
      if (inv_en) valid_d[inv_addr] = 1'b0;
      if (wr_en)  valid_d[wr_addr]  = 1'b1;
      count_d = count_q + (ADDR_WIDTH+1)'(inc) - (ADDR_WIDTH+1)'(dec);
    end
  end

  // Read port works on pre-edge state; a miss returns 0 so unwritten
  // storage never leaks out. rd_data holds between reads.
  always_comb begin
    rd_hit_d  = valid_q[rd_addr];
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = rd_hit_d ? mem_q[rd_addr] : '0;
  end

  // Array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en && !rst && !clr) mem_q[wr_addr] <= wr_data;
  end

  // Valid bits, count and read-port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_hit_q   <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
      rd_hit_q   <= rd_en && rd_hit_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_hit   = rd_hit_q;
  assign count    = count_q;

`ifdef CANDBANK_SCAN_EN
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} scan_state_e;

  scan_state_e           state_q;
  logic [ADDR_WIDTH-1:0] idx_q, run_addr_q, best_addr_q;
  logic [WORD_WIDTH-1:0] run_data_q, best_data_q;
  logic                  run_found_q, best_found_q, busy_q, done_q;
  logic                  take;

  // Strictly greater keeps the lowest index on ties.
  assign take = valid_q[idx_q] && (!run_found_q || (mem_q[idx_q] > run_data_q));

  // Scan FSM: one entry per cycle, results latched on leaving DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      run_found_q  <= 1'b0;
      run_addr_q   <= '0;
      run_data_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      best_found_q <= 1'b0;
      best_addr_q  <= '0;
      best_data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (scan_start) begin
          state_q     <= S_SCAN;
          idx_q       <= '0;
          run_found_q <= 1'b0;
          run_addr_q  <= '0;
          run_data_q  <= '0;
          busy_q      <= 1'b1;
        end
        S_SCAN: begin
          if (take) begin
            run_found_q <= 1'b1;
            run_addr_q  <= idx_q;
            run_data_q  <= mem_q[idx_q];
          end
          if (idx_q == ADDR_WIDTH'(DEPTH-1)) state_q <= S_DONE;
          else                               idx_q   <= idx_q + 1'b1;
        end
        S_DONE: begin
          best_found_q <= run_found_q;
          best_addr_q  <= run_addr_q;
          best_data_q  <= run_data_q;
          done_q       <= 1'b1;
          busy_q       <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign scan_busy  = busy_q;
  assign scan_done  = done_q;
  assign best_found = best_found_q;
  assign best_addr  = best_addr_q;
  assign best_data  = best_data_q;
`else
  logic unused_scan_start;
  assign unused_scan_start = scan_start;
  assign scan_busy  = 1'b0;
  assign scan_done  = 1'b0;
  assign best_found = 1'b0;
  assign best_addr  = '0;
  assign best_data  = '0;
`endif

endmodule
